// File: rtl/pong_vram_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pong_vram_pkg: shared fill-state encoding and default geometry for pong_vram_db
// Revision: 1.0
// ----------------------------------------------------------------------------
package pong_vram_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DEPTH  = 96;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

endpackage
`default_nettype wire

// File: rtl/pong_vram_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pong_vram_bank: one DEPTH x DATA_W bank, one write port, two registered read ports
// Revision: 1.0
// ----------------------------------------------------------------------------
module pong_vram_bank #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 96,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              a_rd_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  output logic [DATA_W-1:0] a_data_o,
  input  logic              b_rd_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  output logic [DATA_W-1:0] b_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] a_data_q;
  logic [DATA_W-1:0] b_data_q;

  // Storage is deliberately left out of reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (we_i && (32'(waddr_i) < DEPTH)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_data_q <= '0;
      b_data_q <= '0;
    end else begin
      if (a_rd_i) begin
        a_data_q <= (32'(a_addr_i) < DEPTH) ? mem_q[a_addr_i] : '0;
      end
      if (b_rd_i) begin
        b_data_q <= (32'(b_addr_i) < DEPTH) ? mem_q[b_addr_i] : '0;
      end
    end
  end

  assign a_data_o = a_data_q;
  assign b_data_o = b_data_q;

endmodule
`default_nettype wire

// File: rtl/pong_vram_db.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pong_vram_db: double-buffered video RAM, CPU on back bank, scan-out on front bank,
// bank swap on vsync. Optional back-bank fill engine: define PONG_VRAM_FILL_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module pong_vram_db
  import pong_vram_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              waitrequest,
  input  logic              swap_req,
  input  logic              vsync,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_value,
  output logic              busy,
  output logic              clear_done,
  input  logic              scan_rd,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_valid,
  output logic              front_sel
);

  logic              front_sel_q, front_sel_d;
  logic              swap_pending_q, swap_pending_d;
  logic              rd_sel_q;
  logic              scan_sel_q;
  logic              scan_valid_q;
  logic              back_w;
  logic              busy_w;
  logic              clear_done_w;
  logic              fill_we_w;
  logic [ADDR_W-1:0] fill_addr_w;
  logic [DATA_W-1:0] fill_data_w;
  logic              cpu_wr_w;
  logic              cpu_rd_w;
  logic              swap_go_w;
  logic              we_w;
  logic [ADDR_W-1:0] waddr_w;
  logic [DATA_W-1:0] wdata_w;
  logic [DATA_W-1:0] cpu_q_w  [2];
  logic [DATA_W-1:0] scan_q_w [2];

  assign back_w      = ~front_sel_q;
  assign waitrequest = chipselect & busy_w;
  assign cpu_wr_w    = chipselect & write & ~waitrequest;
  assign cpu_rd_w    = chipselect & read & ~waitrequest;

`ifdef PONG_VRAM_FILL_EN
  localparam logic [ADDR_W-1:0] C_LAST   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] C_PENULT = ADDR_W'(DEPTH - 2);

  fill_state_e       state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] fill_val_q;
  logic              clear_done_q;

  // clear_done is registered one cycle early so it is high during the last write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      fill_val_q   <= '0;
      clear_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_start) begin
            state_q      <= FILL;
            cnt_q        <= '0;
            fill_val_q   <= clear_value;
            clear_done_q <= (DEPTH == 32'd1);
          end
        end
        FILL: begin
          if (cnt_q == C_LAST) begin
            state_q      <= IDLE;
            clear_done_q <= 1'b0;
          end else begin
            cnt_q        <= cnt_q + 1'b1;
            clear_done_q <= (cnt_q == C_PENULT);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_w       = (state_q == FILL);
  assign clear_done_w = clear_done_q;
  assign fill_we_w    = busy_w;
  assign fill_addr_w  = cnt_q;
  assign fill_data_w  = fill_val_q;
`else
  logic unused_fill_inputs;
  assign unused_fill_inputs = ^{clear_start, clear_value};
  assign busy_w       = 1'b0;
  assign clear_done_w = 1'b0;
  assign fill_we_w    = 1'b0;
  assign fill_addr_w  = '0;
  assign fill_data_w  = '0;
`endif

  assign we_w    = fill_we_w | cpu_wr_w;
  assign waddr_w = fill_we_w ? fill_addr_w : address;
  assign wdata_w = fill_we_w ? fill_data_w : writedata;

  // The back bank cannot change while busy, so fill and CPU share its write port safely.
  assign swap_go_w      = vsync & (swap_pending_q | swap_req) & ~busy_w;
  assign front_sel_d    = front_sel_q ^ swap_go_w;
  assign swap_pending_d = ~swap_go_w & (swap_pending_q | swap_req);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      rd_sel_q       <= 1'b0;
      scan_sel_q     <= 1'b0;
      scan_valid_q   <= 1'b0;
    end else begin
      front_sel_q    <= front_sel_d;
      swap_pending_q <= swap_pending_d;
      scan_valid_q   <= scan_rd;
      if (cpu_rd_w) begin
        rd_sel_q <= back_w;
      end
      if (scan_rd) begin
        scan_sel_q <= front_sel_q;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    pong_vram_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk      (clk),
      .reset_n  (reset_n),
      .we_i     (we_w && (back_w == 1'(g))),
      .waddr_i  (waddr_w),
      .wdata_i  (wdata_w),
      .a_rd_i   (cpu_rd_w && (back_w == 1'(g))),
      .a_addr_i (address),
      .a_data_o (cpu_q_w[g]),
      .b_rd_i   (scan_rd && (front_sel_q == 1'(g))),
      .b_addr_i (scan_addr),
      .b_data_o (scan_q_w[g])
    );
  end

  assign readdata   = cpu_q_w[rd_sel_q];
  assign scan_data  = scan_q_w[scan_sel_q];
  assign scan_valid = scan_valid_q;
  assign front_sel  = front_sel_q;
  assign busy       = busy_w;
  assign clear_done = clear_done_w;

endmodule
`default_nettype wire

// File: tb/tb_pong_vram_db.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pong_vram_db: randomized scoreboard bench for pong_vram_db
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_pong_vram_db;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 96;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
`ifdef PONG_VRAM_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              chipselect, write, read;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;
  logic              swap_req, vsync, clear_start;
  logic [DATA_W-1:0] clear_value;
  logic              busy, clear_done;
  logic              scan_rd;
  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] scan_data;
  logic              scan_valid;
  logic              front_sel;

  always #5 clk = ~clk;

  pong_vram_db #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
    .swap_req(swap_req), .vsync(vsync), .clear_start(clear_start), .clear_value(clear_value),
    .busy(busy), .clear_done(clear_done), .scan_rd(scan_rd), .scan_addr(scan_addr),
    .scan_data(scan_data), .scan_valid(scan_valid), .front_sel(front_sel)
  );

  typedef struct packed {
    logic front;
    logic busy;
    logic done;
    logic wt;
    logic svalid;
  } stat_t;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mem [2][DEPTH];
  bit          m_front = 1'b0;
  bit          m_pend = 1'b0;
  bit          m_srd_prev = 1'b0;
  int          fill_left = 0;
  logic [7:0]  fill_val = '0;
  stat_t       stat_q[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  scan_q[$];
  bit          mon_en = 1'b0;
  logic [7:0]  rd_last = '0;
  logic        rd_fire;
  bit          acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_fire <= 1'b0;
    else          rd_fire <= chipselect & read & ~waitrequest;
  end

  // Monitor: pops the scoreboard whenever the DUT presents data.
  always @(negedge clk) begin
    if (mon_en) begin
      stat_t s;
      if (stat_q.size() > 0) begin
        s = stat_q.pop_front();
        check("front_sel", front_sel, s.front);
        check("busy", busy, s.busy);
        check("clear_done", clear_done, s.done);
        check("waitrequest", waitrequest, s.wt);
        check("scan_valid", scan_valid, s.svalid);
      end
      if (rd_fire) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL readdata_unexpected: got read completion expected none");
        end else begin
          rd_last = rd_q.pop_front();
          check("readdata", readdata, rd_last);
        end
      end else begin
        check("readdata_hold", readdata, rd_last);
      end
      if (scan_valid) begin
        if (scan_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scan_unexpected: got scan_valid expected none");
        end else begin
          check("scan_data", scan_data, scan_q.pop_front());
        end
      end
    end
  end

  task automatic idle();
    chipselect = 0; write = 0; read = 0; address = '0; writedata = '0;
    swap_req = 0; vsync = 0; clear_start = 0; clear_value = '0;
    scan_rd = 0; scan_addr = '0;
  endtask

  // One clock interval: record expectations from the current inputs, advance the model.
  task automatic step(output bit accepted);
    stat_t s;
    bit    mbusy;
    int    back;
    mbusy = (fill_left > 0);
    back  = m_front ? 0 : 1;
    s.front  = m_front;
    s.busy   = mbusy;
    s.done   = mbusy && (fill_left == 1);
    s.wt     = chipselect && mbusy;
    s.svalid = m_srd_prev;
    stat_q.push_back(s);
    accepted = chipselect && !mbusy && (read || write);
    if (accepted && read)
      rd_q.push_back((address < DEPTH) ? mem[back][address] : 8'h00);
    if (scan_rd)
      scan_q.push_back((scan_addr < DEPTH) ? mem[1-back][scan_addr] : 8'h00);
    m_srd_prev = scan_rd;
    if (accepted && write && (address < DEPTH)) mem[back][address] = writedata;
    if (mbusy) begin
      mem[back][DEPTH-fill_left] = fill_val;
      fill_left--;
    end else if (clear_start && FILL_EN) begin
      fill_left = DEPTH;
      fill_val  = clear_value;
    end
    if (vsync && (m_pend || swap_req) && !mbusy) begin
      m_front = !m_front;
      m_pend  = 1'b0;
    end else if (swap_req) begin
      m_pend = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic cpu_read(input int a);
    idle(); chipselect = 1; read = 1; address = ADDR_W'(a); step(acc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_readdata", readdata, 0);
    check("rst_scan_data", scan_data, 0);
    check("rst_scan_valid", scan_valid, 0);
    check("rst_front_sel", front_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_clear_done", clear_done, 0);
    check("rst_waitrequest", waitrequest, 0);
    @(posedge clk); #1;
    reset_n = 1;
    mon_en  = 1;

    // Give both banks known contents.
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < int'(DEPTH); a++) begin
        idle(); chipselect = 1; write = 1; address = ADDR_W'(a);
        writedata = 8'($urandom); step(acc);
      end
      idle(); swap_req = 1; vsync = 1; step(acc);
    end

    // Write, request swap, swap on vsync, scan the new front bank.
    idle(); chipselect = 1; write = 1; address = 3; writedata = 8'h5A; step(acc);
    idle(); swap_req = 1; step(acc);
    idle(); vsync = 1; step(acc);
    idle(); scan_rd = 1; scan_addr = 3; step(acc);
    idle(); step(acc);

    // Out-of-range write is a no-op and read returns zero.
    cpu_read(5);
    idle(); chipselect = 1; write = 1; address = 100; writedata = 8'hEE; step(acc);
    cpu_read(100);
    cpu_read(4);
    idle(); scan_rd = 1; scan_addr = 100; step(acc);
    idle(); step(acc);

`ifdef PONG_VRAM_FILL_EN
    // Full fill, then read both ends of the back bank.
    idle(); clear_start = 1; clear_value = 8'h11; step(acc);
    idle(); clear_start = 1; clear_value = 8'h99;
    for (int i = 0; i < int'(DEPTH); i++) step(acc);
    cpu_read(0);
    cpu_read(95);
    idle(); step(acc);

    // CPU write stalled by a fill is accepted exactly once after it.
    idle(); clear_start = 1; clear_value = 8'h33; step(acc);
    idle(); chipselect = 1; write = 1; address = 10; writedata = 8'hC3;
    for (int n = 0; n < 200; n++) begin
      step(acc);
      if (acc) break;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL stalled_write: got never accepted expected accepted");
    end
    cpu_read(10);
    cpu_read(11);

    // vsync during fill leaves the swap pending; the next vsync after the fill swaps.
    idle(); clear_start = 1; clear_value = 8'h44; step(acc);
    idle(); swap_req = 1; step(acc);
    idle(); vsync = 1; step(acc);
    idle();
    for (int i = 0; i < int'(DEPTH); i++) step(acc);
    idle(); vsync = 1; step(acc);
    idle(); step(acc);

    // Reset in the middle of a fill: writes stop, bank contents survive.
    if (!m_front) begin
      idle(); swap_req = 1; vsync = 1; step(acc);
    end
    idle(); clear_start = 1; clear_value = 8'h22; step(acc);
    idle();
    for (int i = 0; i < 40; i++) step(acc);
    reset_n = 0;
    mon_en  = 0;
    #1;
    check("midfill_rst_busy", busy, 0);
    check("midfill_rst_front_sel", front_sel, 0);
    check("midfill_rst_clear_done", clear_done, 0);
    stat_q.delete();
    m_front = 0; m_pend = 0; m_srd_prev = 0; fill_left = 0; rd_last = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    mon_en  = 1;
    idle(); scan_rd = 1; scan_addr = 39; step(acc);
    scan_addr = 40; step(acc);
    scan_addr = 95; step(acc);
    idle(); step(acc);
`endif

    // Randomized traffic on all ports.
    for (int i = 0; i < 800; i++) begin
      int r;
      idle();
      r = int'($urandom_range(0, 3));
      chipselect = (r != 0);
      write      = (r == 1);
      read       = (r == 2);
      address    = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom_range(DEPTH, 127))
                                               : ADDR_W'($urandom_range(0, DEPTH-1));
      writedata   = 8'($urandom);
      swap_req    = ($urandom_range(0, 9) == 0);
      vsync       = ($urandom_range(0, 7) == 0);
      clear_start = ($urandom_range(0, 99) == 0);
      clear_value = 8'($urandom);
      scan_rd     = $urandom_range(0, 1) == 1;
      scan_addr   = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom_range(DEPTH, 127))
                                                : ADDR_W'($urandom_range(0, DEPTH-1));
      step(acc);
    end
    idle();
    repeat (3) step(acc);

    checks++;
    if (rd_q.size() != 0 || scan_q.size() != 0 || stat_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got rd=%0d scan=%0d stat=%0d pending expected 0",
               rd_q.size(), scan_q.size(), stat_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pong_vram_db.md
PONG_VRAM_DB -- requirements
Module: pong_vram_db

Interface
REQ-001 Parameter DATA_W, default 8, pixel word width in bits.
REQ-002 Parameter DEPTH, default 96, words per bank.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH), address width for both ports.
REQ-004 Port clk  in  1  single clock for all logic.
REQ-005 Port reset_n  in  1  asynchronous, active-low reset.
REQ-006 Port chipselect, write, read  in  1 each  Avalon-MM slave controls for the CPU port.
REQ-007 Port address  in  ADDR_W  CPU word address.
REQ-008 Port writedata  in  DATA_W  CPU write data.
REQ-009 Port readdata  out  DATA_W  CPU read data, back bank.
REQ-010 Port waitrequest  out  1  CPU stall.
REQ-011 Port swap_req  in  1  one-cycle request to exchange the front and back banks.
REQ-012 Port vsync  in  1  one-cycle frame-boundary strobe.
REQ-013 Port clear_start, clear_value  in  1, DATA_W  start a fill of the back bank with a value.
REQ-014 Port busy, clear_done  out  1 each  fill in progress; one-cycle fill completion pulse.
REQ-015 Port scan_rd, scan_addr  in  1, ADDR_W  display read of the front bank.
REQ-016 Port scan_data, scan_valid  out  DATA_W, 1  display read data and its qualifier.
REQ-017 Port front_sel  out  1  index of the current front bank.

Function
REQ-018 The block SHALL hold two banks of DEPTH x DATA_W; CPU writes, CPU reads and fills SHALL target the back bank (!front_sel); scan reads SHALL target the front bank.
REQ-019 A CPU write SHALL occur when chipselect&write&!waitrequest, and SHALL take effect at that clock edge.
REQ-020 readdata SHALL be valid exactly one cycle after an accepted read (chipselect&read&!waitrequest), and SHALL hold its value otherwise.
REQ-021 scan_data SHALL be registered one cycle after scan_rd; scan_valid SHALL be scan_rd delayed one cycle.
REQ-022 An address >= DEPTH SHALL make a write a no-op and SHALL make a read return 0 on either port.
REQ-023 waitrequest SHALL equal chipselect&busy (combinational).
REQ-024 The fill FSM SHALL have states IDLE and FILL; IDLE->FILL on clear_start, with clear_value latched and the counter set to 0.
REQ-025 In FILL the FSM SHALL write the latched value to counter address each cycle; the fill SHALL complete after DEPTH cycles, pulse clear_done on the last write cycle, and return to IDLE.
REQ-026 busy SHALL be high exactly while in FILL; clear_start while busy SHALL be ignored.
REQ-027 swap_req SHALL set swap_pending; front_sel SHALL toggle, and swap_pending SHALL clear, on a cycle with vsync&(swap_pending|swap_req)&!busy.
REQ-028 A vsync during busy SHALL leave the swap pending until the next qualifying vsync.
REQ-029 A scan read in the same cycle as a swap SHALL read the pre-swap front bank.

Reset
REQ-030 While reset_n is low: fill FSM=IDLE, counter=0, swap_pending=0, front_sel=0, busy=0, clear_done=0, scan_valid=0, readdata=0, scan_data=0.
REQ-031 A reset during FILL SHALL abort the fill with no further writes; bank contents SHALL NOT be reset.

Configuration
REQ-032 Macro PONG_VRAM_FILL_EN: when defined, the fill engine SHALL be compiled in per REQ-024..026.
REQ-033 When PONG_VRAM_FILL_EN is not defined, clear_start SHALL be ignored, busy and clear_done SHALL be tied to 0, and waitrequest SHALL be tied to 0.

Structure
REQ-034 The shared package pong_vram_pkg SHALL hold the fill-state enum (IDLE, FILL) and the default DATA_W/DEPTH constants.
REQ-035 Each bank SHALL be one instance of sub-module pong_vram_bank (one write port, two registered read ports); bank muxing and the FSM SHALL stay in the top level.

Verification
REQ-036 Write 0x5A to address 3, swap_req, vsync, scan_rd address 3 -> front_sel=1, scan_data=0x5A with scan_valid one cycle after scan_rd.
REQ-037 clear_start with value 0x11 (DEPTH=96) -> busy high for 96 cycles, clear_done pulses once, CPU read of addresses 0 and 95 returns 0x11.
REQ-038 CPU write during busy -> waitrequest=1 until busy falls, then the write is accepted once.
REQ-039 swap_req, then vsync during busy -> no toggle; next vsync after fill -> front_sel toggles.
REQ-040 Write to address 100 (DEPTH=96) -> no bank change; read of address 100 -> readdata=0.
REQ-041 reset_n low at fill cycle 40 -> busy=0 and front_sel=0 immediately; addresses >= 40 keep their prior contents.
